// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan: frame-snapshotted, time-multiplexed common-anode 7-segment BCD driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module bcd_sevenseg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    ovf,
    input  logic                    ovf_clr,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [TW-1:0]           tick_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap;
    logic                    ovf_flag;
    logic [3:0]              cur;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   one_hot;
    logic                    tick_end;
    logic                    last;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'h40;
            4'd1: decode = 7'h79;
            4'd2: decode = 7'h24;
            4'd3: decode = 7'h30;
            4'd4: decode = 7'h19;
            4'd5: decode = 7'h12;
            4'd6: decode = 7'h02;
            4'd7: decode = 7'h78;
            4'd8: decode = 7'h00;
            4'd9: decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign cur      = snap[{idx, 2'b00} +: 4];
    assign one_hot  = NUM_DIGITS'(1) << idx;
    assign tick_end = tick_cnt == TW'(REFRESH_DIV - 1);
    assign last     = idx == IW'(NUM_DIGITS - 1);

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank only when it and every digit above it are zero.
    always_comb begin
        logic zeros;
        blank = '0;
        zeros = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zeros    = zeros & (snap[4*k +: 4] == 4'd0);
            blank[k] = zeros;
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            tick_cnt <= '0;
            idx      <= '0;
            ovf_flag <= 1'b0;
            snap     <= digits;
            an       <= '1;
            seg      <= 7'h7F;
            dp       <= 1'b1;
        end else begin
            if (enable) begin
                tick_cnt <= tick_end ? '0 : tick_cnt + TW'(1);
                if (tick_end) begin
                    idx <= last ? '0 : idx + IW'(1);
                    if (last) snap <= digits;
                end
            end
            ovf_flag <= ovf | (ovf_flag & ~ovf_clr);
            an       <= blank[idx] ? '1 : ~one_hot;
            seg      <= blank[idx] ? 7'h7F : decode(cur);
            dp       <= !(idx == '0 && ovf_flag);
        end
    end
endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// tb_bcd_sevenseg_scan: directed checks of scan timing, snapshot, decode, freeze, overflow dp and blanking.
module tb_bcd_sevenseg_scan;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digits = 16'h0006;
    logic        ovf = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          n_assert = 0;
    int          n_fail = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit blank_en = 1'b1;
`else
    localparam bit blank_en = 1'b0;
`endif

    bcd_sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .clr(clr), .enable(enable), .digits(digits),
        .ovf(ovf), .ovf_clr(ovf_clr), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        n_assert += 3;
        assert (an === ea) else begin
            n_fail++;
            $error("FAIL %s an observed=%b expected=%b", tag, an, ea);
        end
        assert (seg === es) else begin
            n_fail++;
            $error("FAIL %s seg observed=%h expected=%h", tag, seg, es);
        end
        assert (dp === ed) else begin
            n_fail++;
            $error("FAIL %s dp observed=%b expected=%b", tag, dp, ed);
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, ea, es, ed);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset", 4'hF, 7'h7F, 1'b1);
        clr = 1'b0;
        enable = 1'b1;
        digits = 16'h1234;
        slot("f1_d0", 4'hE, 7'h02, 1'b1, 4);
        slot("f1_d1", blank_en ? 4'hF : 4'hD, blank_en ? 7'h7F : 7'h40, 1'b1, 4);
        slot("f1_d2", blank_en ? 4'hF : 4'hB, blank_en ? 7'h7F : 7'h40, 1'b1, 4);
        slot("f1_d3", blank_en ? 4'hF : 4'h7, blank_en ? 7'h7F : 7'h40, 1'b1, 4);
        for (int f = 0; f < 2; f++) begin
            slot("scan_d0", 4'hE, 7'h19, 1'b1, 4);
            slot("scan_d1", 4'hD, 7'h30, 1'b1, 4);
            if (f == 1) digits = 16'h5678;
            slot("scan_d2", 4'hB, 7'h24, 1'b1, 4);
            slot("scan_d3", 4'h7, 7'h79, 1'b1, 4);
        end
        slot("snap_d0", 4'hE, 7'h00, 1'b1, 4);
        slot("snap_d1", 4'hD, 7'h78, 1'b1, 4);
        slot("snap_d2", 4'hB, 7'h02, 1'b1, 4);
        digits = 16'h00A0;
        slot("snap_d3", 4'h7, 7'h12, 1'b1, 4);
        slot("inv_d0", 4'hE, 7'h40, 1'b1, 4);
        slot("inv_d1", 4'hD, 7'h3F, 1'b1, 2);
        enable = 1'b0;
        slot("freeze", 4'hD, 7'h3F, 1'b1, 10);
        enable = 1'b1;
        digits = 16'h1234;
        slot("resume_d1", 4'hD, 7'h3F, 1'b1, 2);
        slot("inv_d2", blank_en ? 4'hF : 4'hB, blank_en ? 7'h7F : 7'h40, 1'b1, 4);
        slot("inv_d3", blank_en ? 4'hF : 4'h7, blank_en ? 7'h7F : 7'h40, 1'b1, 4);
        ovf = 1'b1;
        slot("ovf_edge", 4'hE, 7'h19, 1'b1, 1);
        ovf = 1'b0;
        slot("ovf_d0", 4'hE, 7'h19, 1'b0, 3);
        slot("ovf_d1", 4'hD, 7'h30, 1'b1, 4);
        slot("ovf_d2", 4'hB, 7'h24, 1'b1, 4);
        slot("ovf_d3", 4'h7, 7'h79, 1'b1, 4);
        slot("keep_d0", 4'hE, 7'h19, 1'b0, 4);
        ovf = 1'b1;
        ovf_clr = 1'b1;
        slot("both_d1", 4'hD, 7'h30, 1'b1, 1);
        ovf = 1'b0;
        ovf_clr = 1'b0;
        slot("both_d1", 4'hD, 7'h30, 1'b1, 3);
        slot("both_d2", 4'hB, 7'h24, 1'b1, 4);
        slot("both_d3", 4'h7, 7'h79, 1'b1, 4);
        slot("set_wins_d0", 4'hE, 7'h19, 1'b0, 4);
        ovf_clr = 1'b1;
        slot("oclr_d1", 4'hD, 7'h30, 1'b1, 1);
        ovf_clr = 1'b0;
        slot("oclr_d1", 4'hD, 7'h30, 1'b1, 3);
        slot("oclr_d2", 4'hB, 7'h24, 1'b1, 4);
        slot("oclr_d3", 4'h7, 7'h79, 1'b1, 4);
        slot("cleared_d0", 4'hE, 7'h19, 1'b1, 4);
        slot("pre_clr_d1", 4'hD, 7'h30, 1'b1, 2);
        clr = 1'b1;
        ovf = 1'b1;
        digits = 16'h0009;
        slot("mid_clr", 4'hF, 7'h7F, 1'b1, 1);
        clr = 1'b0;
        ovf = 1'b0;
        slot("restart_d0", 4'hE, 7'h10, 1'b1, 4);
        slot("restart_d1", blank_en ? 4'hF : 4'hD, blank_en ? 7'h7F : 7'h40, 1'b1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_sevenseg_scan.md
Name: bcd_sevenseg_scan

Overview:
- Downstream consumer of the cascaded BCD_Counter stages. It drives a multiplexed common-anode 7-segment display on the lab board.
- Takes NUM_DIGITS packed BCD digits plus the counter carry-out pulse, snapshots them once per scan frame, and time-multiplexes them onto the anode and segment lines.
- A sticky overflow flag from CO lights the decimal point of digit 0.

Parameters:
- NUM_DIGITS, 4: digits scanned; range 2..8.
- REFRESH_DIV, 100000: clk cycles each digit is held; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- enable  in  1  scan advance enable; 0 freezes the scan.
- digits  in  4*NUM_DIGITS  packed BCD; digits[3:0] is digit 0 (least significant).
- ovf  in  1  counter carry-out pulse (CO); sets the sticky flag.
- ovf_clr  in  1  clears the sticky flag.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low; seg[0]=a.
- dp  out  1  decimal point, active-low.

Behaviour:
- Single clock domain. All state updates at posedge clk.
- clr=1 at an edge (highest priority):
  - tick_cnt=0, idx=0, ovf_flag=0, snap<=digits.
  - Outputs: an=all 1s, seg=7'h7F, dp=1.
- Prescaler, when enable=1:
  - tick_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: tick_cnt wraps to 0 and idx advances (idx+1) mod NUM_DIGITS.
  - When that advance wraps idx from NUM_DIGITS-1 to 0, snap<=digits in the same edge (frame snapshot, no tearing).
- enable=0: tick_cnt, idx and snap hold. Outputs keep showing the current digit.
- Output register, every non-reset edge:
  - an = ~(1<<idx); seg = decode(snap[idx]).
  - dp = 0 iff idx==0 and ovf_flag==1, else 1.
  - Latency: outputs reflect the idx/snap/ovf_flag values present before the edge (1-cycle registered).
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values 10..15 show a dash, 3F.
- Overflow flag:
  - ovf=1 sets ovf_flag; ovf_clr=1 clears it.
  - ovf and ovf_clr in the same cycle: set wins.
  - clr clears it regardless.
- Mid-frame digit changes are invisible until the next frame wrap.
- clr asserted mid-frame restarts the scan at digit 0 with a fresh snapshot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k>0 is blanked when snap[k] and every higher snap digit are all 0.
  - A blanked digit drives an all 1s and seg=7'h7F during its slot. Scan timing is unchanged.
  - Digit 0 is never blanked. Invalid codes (>9) count as nonzero.
- Undefined: all digits are always shown, including leading zeros.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Reset: clr=1 for one edge with digits=16'h0006 -> an=4'hF, seg=7'h7F, dp=1. Then clr=0, enable=1 -> next edge an=4'b1110, seg=7'h02.
2. Scan: digits=16'h1234, enable=1 -> an steps 1110/1101/1011/0111, each held 4 cycles, with seg 19/30/24/79; pattern repeats every 16 cycles.
3. Snapshot: digits changes 1234 to 5678 while idx=2 -> slots 2 and 3 still show 24/79; from the next idx=0 slot seg shows 5678 (00/78/02/12).
4. Invalid/hold: digits=16'h00A0 -> slot 1 seg=7'h3F. Drop enable for 10 cycles -> an/seg frozen, tick_cnt and idx unchanged.
5. Overflow: one-cycle ovf -> dp=0 in every slot 0, dp=1 elsewhere, persisting across frames. ovf and ovf_clr together -> flag stays set. ovf_clr alone -> dp=1 afterwards.
6. Blanking, digits=16'h0006:
   - With LEADING_ZERO_BLANK_EN: an only ever 1110 or 1111.
   - Without: all four slots active, showing 40/40/40/02.
